dma_queue_arbiter: RTL and testbench

- Shares one DCS descriptor-write channel between the SQ and RQ DMA FIFOs, which hold 112-bit work entries.
- Sits between the RDMA operation stage and the DMA request engine.
- Each grant pops one entry, writes it to the DCS window as four 32-bit beats, then writes a doorbell word.
- Weighted round-robin arbitration between the two queues.

---
 rtl/dma_arb_pkg.sv | 39 +++
 rtl/wrr_pick.sv | 88 ++++++++
 rtl/dma_queue_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_dma_queue_arbiter.sv | 431 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_arb_pkg.sv
// Shared types and helpers for the SQ/RQ DMA queue arbiter.
// Optional grant statistics are enabled with DMA_ARB_STATS_EN.
package dma_arb_pkg;

  localparam int WQE_W    = 112;
  localparam int BEAT_CNT = 4;
  localparam int BEAT_W   = 2;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BEAT     = 2'd1,
    DOORBELL = 2'd2
  } arb_state_e;

  localparam logic Q_SQ = 1'b0;
  localparam logic Q_RQ = 1'b1;

  // Slice one 32-bit descriptor beat; the last beat carries 16 bits.
  function automatic logic [31:0] beat_word(
    input logic [WQE_W-1:0]  wqe,
    input logic [BEAT_W-1:0] idx
  );
    logic [31:0] w;
    unique case (idx)
      2'd0:    w = wqe[31:0];
      2'd1:    w = wqe[63:32];
      2'd2:    w = wqe[95:64];
      default: w = {16'h0, wqe[111:96]};
    endcase
    return w;
  endfunction

  function automatic logic [3:0] beat_be(
    input logic [BEAT_W-1:0] idx
  );
    return (idx == 2'(BEAT_CNT - 1)) ? 4'h3 : 4'hF;
  endfunction

endpackage

// File: rtl/wrr_pick.sv
// Weighted round-robin choice between two requesters.
// Side A is queue id 0, side B is queue id 1.
module wrr_pick
  import dma_arb_pkg::*;
#(
  parameter int unsigned A_WEIGHT = 2,
  parameter int unsigned B_WEIGHT = 1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic req_a_i,
  input  logic req_b_i,
  input  logic take_i,
  input  logic done_i,
  input  logic done_id_i,
  output logic pick_o
);

  localparam logic [3:0] A_M1 = 4'(A_WEIGHT - 1);
  localparam logic [3:0] B_M1 = 4'(B_WEIGHT - 1);

  logic       last_q;
  logic       last_d;
  logic [3:0] credit_q;
  logic [3:0] credit_d;
  logic [3:0] reload;

  logic only_a;
  logic only_b;
  logic both_stay;
  logic both_swap;

  assign only_a    = req_a_i & ~req_b_i;
  assign only_b    = ~req_a_i & req_b_i;
  assign both_stay = req_a_i & req_b_i &
                     (credit_q != 4'd0);
  assign both_swap = req_a_i & req_b_i &
                     (credit_q == 4'd0);

  // Choose a side and the credit it leaves behind.
  always_comb begin
    pick_o = last_q;
    reload = credit_q;
    unique case (1'b1)
      only_a: begin
        pick_o = Q_SQ;
        reload = A_M1;
      end
      only_b: begin
        pick_o = Q_RQ;
        reload = B_M1;
      end
      both_stay: begin
        pick_o = last_q;
        reload = credit_q - 4'd1;
      end
      both_swap: begin
        pick_o = ~last_q;
        reload = (last_q == Q_SQ) ? B_M1 : A_M1;
      end
      default: ;
    endcase
  end

  // Credit moves on a grant; last side moves when an entry retires.
  always_comb begin
    credit_d = credit_q;
    last_d   = last_q;
    if (take_i) begin
      credit_d = reload;
    end
    if (done_i) begin
      last_d = done_id_i;
    end
  end

  // Reset leaves B as last so A wins the first tie.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      credit_q <= 4'd0;
      last_q   <= Q_RQ;
    end else begin
      credit_q <= credit_d;
      last_q   <= last_d;
    end
  end

endmodule

// File: rtl/dma_queue_arbiter.sv
// Shares the DCS descriptor-write channel between SQ and RQ FIFOs.
// Define DMA_ARB_STATS_EN for per-queue doorbell counters.
module dma_queue_arbiter
  import dma_arb_pkg::*;
#(
  parameter int unsigned SQ_WEIGHT     = 2,
  parameter int unsigned RQ_WEIGHT     = 1,
  parameter logic [7:0]  BASE_ADDR     = 8'h00,
  parameter logic [7:0]  DOORBELL_ADDR = 8'h10
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [WQE_W-1:0] sqFifoData,
  input  logic             sqFifoEmpty,
  output logic             sqFifoPop,
  input  logic [WQE_W-1:0] rqFifoData,
  input  logic             rqFifoEmpty,
  output logic             rqFifoPop,
  output logic [7:0]       dcsAddress,
  output logic [31:0]      dcsWriteData,
  output logic [3:0]       dcsByteEnable,
  output logic             dcsChipSelect,
  output logic             dcsWrite,
  input  logic             dcsWaitRequest,
`ifdef DMA_ARB_STATS_EN
  input  logic             statClear,
  output logic [15:0]      sqGrantCnt,
  output logic [15:0]      rqGrantCnt,
`endif
  output logic             busy,
  output logic             grantQ
);

  localparam logic [7:0] BEAT1_ADDR = BASE_ADDR + 8'd1;
  localparam logic [7:0] BEAT2_ADDR = BASE_ADDR + 8'd2;
  localparam logic [7:0] BEAT3_ADDR = BASE_ADDR + 8'd3;

  if (SQ_WEIGHT < 1 || SQ_WEIGHT > 15) begin : g_bad_sq_weight
    $error("SQ_WEIGHT must be 1..15");
  end

  if (RQ_WEIGHT < 1 || RQ_WEIGHT > 15) begin : g_bad_rq_weight
    $error("RQ_WEIGHT must be 1..15");
  end

  if (BASE_ADDR  == DOORBELL_ADDR ||
      BEAT1_ADDR == DOORBELL_ADDR ||
      BEAT2_ADDR == DOORBELL_ADDR ||
      BEAT3_ADDR == DOORBELL_ADDR) begin : g_bad_addr
    $error("descriptor window overlaps doorbell");
  end

  arb_state_e       state_q;
  logic             run_q;
  logic [WQE_W-1:0] hold_q;
  logic [1:0]       beat_q;
  logic [1:0]       beat_nx;
  logic             grant_q;
  logic [7:0]       addr_q;
  logic [31:0]      data_q;
  logic [3:0]       be_q;
  logic             cs_q;
  logic             wr_q;

  logic             pick;
  logic             take;
  logic             accept;
  logic             done;
  logic [WQE_W-1:0] sel_data;

  assign accept   = ~dcsWaitRequest;
  assign take     = run_q & enable & (state_q == IDLE) &
                    (~sqFifoEmpty | ~rqFifoEmpty);
  assign done     = (state_q == DOORBELL) & accept;
  assign beat_nx  = beat_q + 2'd1;
  assign sel_data = (pick == Q_RQ) ? rqFifoData : sqFifoData;

  assign sqFifoPop     = take & (pick == Q_SQ);
  assign rqFifoPop     = take & (pick == Q_RQ);
  assign busy          = (state_q != IDLE);
  assign grantQ        = grant_q;
  assign dcsAddress    = addr_q;
  assign dcsWriteData  = data_q;
  assign dcsByteEnable = be_q;
  assign dcsChipSelect = cs_q;
  assign dcsWrite      = wr_q;

  wrr_pick #(
    .A_WEIGHT (SQ_WEIGHT),
    .B_WEIGHT (RQ_WEIGHT)
  ) u_pick (
    .clk_i     (clock),
    .rst_ni    (reset),
    .req_a_i   (~sqFifoEmpty),
    .req_b_i   (~rqFifoEmpty),
    .take_i    (take),
    .done_i    (done),
    .done_id_i (grant_q),
    .pick_o    (pick)
  );

  // Grant, serialise four beats, then ring the doorbell.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      run_q   <= 1'b0;
      hold_q  <= '0;
      beat_q  <= 2'd0;
      grant_q <= 1'b0;
      addr_q  <= 8'h00;
      data_q  <= 32'h0;
      be_q    <= 4'h0;
      cs_q    <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      run_q <= 1'b1;
      unique case (state_q)
        IDLE: begin
          if (take) begin
            hold_q  <= sel_data;
            grant_q <= pick;
            beat_q  <= 2'd0;
            addr_q  <= BASE_ADDR;
            data_q  <= beat_word(sel_data, 2'd0);
            be_q    <= beat_be(2'd0);
            cs_q    <= 1'b1;
            wr_q    <= 1'b1;
            state_q <= BEAT;
          end
        end
        BEAT: begin
          if (accept) begin
            if (beat_q == 2'(BEAT_CNT - 1)) begin
              addr_q  <= DOORBELL_ADDR;
              data_q  <= {31'h0, grant_q};
              be_q    <= 4'hF;
              state_q <= DOORBELL;
            end else begin
              beat_q <= beat_nx;
              addr_q <= BASE_ADDR + {6'h0, beat_nx};
              data_q <= beat_word(hold_q, beat_nx);
              be_q   <= beat_be(beat_nx);
            end
          end
        end
        DOORBELL: begin
          if (accept) begin
            addr_q  <= 8'h00;
            data_q  <= 32'h0;
            be_q    <= 4'h0;
            cs_q    <= 1'b0;
            wr_q    <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          cs_q    <= 1'b0;
          wr_q    <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

`ifdef DMA_ARB_STATS_EN
  logic [15:0] sq_cnt_q;
  logic [15:0] rq_cnt_q;

  assign sqGrantCnt = sq_cnt_q;
  assign rqGrantCnt = rq_cnt_q;

  // Saturating doorbell counters; clear beats a same-cycle count.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sq_cnt_q <= 16'h0;
      rq_cnt_q <= 16'h0;
    end else if (statClear) begin
      sq_cnt_q <= 16'h0;
      rq_cnt_q <= 16'h0;
    end else if (done) begin
      if (grant_q == Q_SQ && sq_cnt_q != 16'hFFFF) begin
        sq_cnt_q <= sq_cnt_q + 16'd1;
      end
      if (grant_q == Q_RQ && rq_cnt_q != 16'hFFFF) begin
        rq_cnt_q <= rq_cnt_q + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dma_queue_arbiter.sv
// Self-checking bench for dma_queue_arbiter.
// Stats checks run only when DMA_ARB_STATS_EN is defined.
module tb_dma_queue_arbiter;

  localparam int         SQ_W = 2;
  localparam int         RQ_W = 1;
  localparam logic [7:0] BASE = 8'h00;
  localparam logic [7:0] DB   = 8'h10;

  logic         clock;
  logic         reset;
  logic         enable;
  logic [111:0] sqFifoData;
  logic         sqFifoEmpty;
  logic         sqFifoPop;
  logic [111:0] rqFifoData;
  logic         rqFifoEmpty;
  logic         rqFifoPop;
  logic [7:0]   dcsAddress;
  logic [31:0]  dcsWriteData;
  logic [3:0]   dcsByteEnable;
  logic         dcsChipSelect;
  logic         dcsWrite;
  logic         dcsWaitRequest;
  logic         busy;
  logic         grantQ;
`ifdef DMA_ARB_STATS_EN
  logic         statClear;
  logic [15:0]  sqGrantCnt;
  logic [15:0]  rqGrantCnt;
`endif

  dma_queue_arbiter #(
    .SQ_WEIGHT     (SQ_W),
    .RQ_WEIGHT     (RQ_W),
    .BASE_ADDR     (BASE),
    .DOORBELL_ADDR (DB)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .enable         (enable),
    .sqFifoData     (sqFifoData),
    .sqFifoEmpty    (sqFifoEmpty),
    .sqFifoPop      (sqFifoPop),
    .rqFifoData     (rqFifoData),
    .rqFifoEmpty    (rqFifoEmpty),
    .rqFifoPop      (rqFifoPop),
    .dcsAddress     (dcsAddress),
    .dcsWriteData   (dcsWriteData),
    .dcsByteEnable  (dcsByteEnable),
    .dcsChipSelect  (dcsChipSelect),
    .dcsWrite       (dcsWrite),
    .dcsWaitRequest (dcsWaitRequest),
`ifdef DMA_ARB_STATS_EN
    .statClear      (statClear),
    .sqGrantCnt     (sqGrantCnt),
    .rqGrantCnt     (rqGrantCnt),
`endif
    .busy           (busy),
    .grantQ         (grantQ)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [7:0]  a;
    logic [31:0] d;
    logic [3:0]  be;
  } wr_t;

  typedef struct {
    int     n_sq;
    int     n_rq;
    int     n_g;
    bit [5:0] seq;
  } arb_vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  logic [111:0] sq_mem[$];
  logic [111:0] rq_mem[$];
  wr_t          exp_q[$];
  wr_t          log_q[$];
  bit           gnt_log[$];

  bit   m_last;
  int   m_streak;
  bit   cur_q;
  bit   rand_wait;
  bit   prev_stall;
  logic [45:0] prev_bus;
  int   since_rst;
  int   n_pops;
  int   busy_seen;

  task automatic check(input string name,
                       input logic [127:0] act,
                       input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [111:0] rand_wqe();
    logic [127:0] r;
    r = {$urandom(), $urandom(), $urandom(), $urandom()};
    return r[111:0];
  endfunction

  function automatic int weight(input bit q);
    return q ? RQ_W : SQ_W;
  endfunction

  // Reference arbiter: length of the current run of grants per queue.
  function automatic bit model_pick(input bit sne, input bit rne);
    if (sne && !rne) return 1'b0;
    if (rne && !sne) return 1'b1;
    if (m_streak < weight(m_last)) return m_last;
    return !m_last;
  endfunction

  task automatic model_commit(input bit q, input bit both);
    if (both && q == m_last) m_streak++;
    else m_streak = 1;
    m_last = q;
  endtask

  task automatic model_reset();
    m_last   = 1'b1;
    m_streak = RQ_W;
  endtask

  task automatic expect_entry(input logic [111:0] d, input bit q);
    wr_t w;
    for (int i = 0; i < 4; i++) begin
      w.a  = BASE + 8'(i);
      w.d  = 32'((d >> (32 * i)) & 112'hFFFF_FFFF);
      w.be = (i == 3) ? 4'h3 : 4'hF;
      exp_q.push_back(w);
    end
    w.a  = DB;
    w.d  = {31'h0, q};
    w.be = 4'hF;
    exp_q.push_back(w);
  endtask

  task automatic fifo_refresh();
    sqFifoEmpty = (sq_mem.size() == 0);
    rqFifoEmpty = (rq_mem.size() == 0);
    sqFifoData  = (sq_mem.size() != 0) ? sq_mem[0] : '0;
    rqFifoData  = (rq_mem.size() != 0) ? rq_mem[0] : '0;
  endtask

  // One clock: observe mid-cycle, then retire pops after the edge.
  task automatic tick();
    bit  ps, pr, q, sne, rne;
    wr_t cur, e;
    @(negedge clock);
    ps  = sqFifoPop;
    pr  = rqFifoPop;
    sne = (sq_mem.size() != 0);
    rne = (rq_mem.size() != 0);
    if (reset) begin
      if (busy) busy_seen++;
      check("cs_tracks_busy", dcsChipSelect, busy);
      check("we_tracks_busy", dcsWrite, busy);
      if (busy) check("grantQ", grantQ, cur_q);
      if (since_rst > 0 && enable && !busy && (sne || rne))
        check("grant_taken", ps | pr, 1'b1);
      if (ps || pr) begin
        n_pops++;
        q = pr;
        check("pop_idle", busy, 1'b0);
        check("pop_onehot", ps & pr, 1'b0);
        check("pop_nonempty", q ? rne : sne, 1'b1);
        check("grant_order", q, model_pick(sne, rne));
        model_commit(q, sne && rne);
        gnt_log.push_back(q);
        cur_q = q;
        if (q ? rne : sne)
          expect_entry(q ? rq_mem[0] : sq_mem[0], q);
      end
      if (prev_stall)
        check("hold_stable",
              {dcsAddress, dcsWriteData, dcsByteEnable,
               dcsChipSelect, dcsWrite}, prev_bus);
      if (dcsChipSelect && dcsWrite && !dcsWaitRequest) begin
        cur.a  = dcsAddress;
        cur.d  = dcsWriteData;
        cur.be = dcsByteEnable;
        log_q.push_back(cur);
        check("write_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("wr_addr", cur.a, e.a);
          check("wr_data", cur.d, e.d);
          check("wr_be", cur.be, e.be);
        end
      end
      prev_stall = dcsChipSelect && dcsWrite && dcsWaitRequest;
      prev_bus   = {dcsAddress, dcsWriteData, dcsByteEnable,
                    dcsChipSelect, dcsWrite};
    end
    @(posedge clock);
    #1;
    if (reset) begin
      since_rst++;
      if (ps && sq_mem.size() != 0) void'(sq_mem.pop_front());
      if (pr && rq_mem.size() != 0) void'(rq_mem.pop_front());
    end
    if (rand_wait) dcsWaitRequest = ($urandom_range(0, 3) == 0);
    fifo_refresh();
  endtask

  task automatic do_reset();
    reset          = 1'b0;
    enable         = 1'b0;
    dcsWaitRequest = 1'b0;
    rand_wait      = 1'b0;
    sq_mem.delete();
    rq_mem.delete();
    exp_q.delete();
    log_q.delete();
    gnt_log.delete();
    model_reset();
    prev_stall = 1'b0;
    fifo_refresh();
    repeat (2) tick();
    check("rst_busy", busy, 1'b0);
    check("rst_cs", dcsChipSelect, 1'b0);
    check("rst_grantQ", grantQ, 1'b0);
    check("rst_addr", dcsAddress, 8'h00);
    reset     = 1'b1;
    since_rst = 0;
    n_pops    = 0;
    busy_seen = 0;
  endtask

  task automatic drain(input int max);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (!busy && sq_mem.size() == 0 &&
          rq_mem.size() == 0 && exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    check("drain_done", ok, 1'b1);
  endtask

  task automatic wait_addr(input logic [7:0] a, input int max);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (busy && dcsChipSelect && dcsAddress == a) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    check("reach_addr", ok, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  arb_vec_t vecs[6];
  wr_t      single[5];

  initial begin
`ifdef DMA_ARB_STATS_EN
    statClear = 1'b0;
`endif
    vecs[0] = '{1, 0, 1, 6'b000000};
    vecs[1] = '{0, 1, 1, 6'b000001};
    vecs[2] = '{4, 2, 6, 6'b100100};
    vecs[3] = '{3, 3, 6, 6'b110100};
    vecs[4] = '{0, 3, 3, 6'b000111};
    vecs[5] = '{2, 4, 6, 6'b111100};

    single[0] = '{8'h00, 32'h2d3c_abcd, 4'hF};
    single[1] = '{8'h01, 32'hdef0_0f1e, 4'hF};
    single[2] = '{8'h02, 32'h5678_9abc, 4'hF};
    single[3] = '{8'h03, 32'h0000_1234, 4'h3};
    single[4] = '{8'h10, 32'h0000_0000, 4'hF};

    // Grant-order vectors, each from a fresh reset.
    for (int v = 0; v < 6; v++) begin
      do_reset();
      for (int i = 0; i < vecs[v].n_sq; i++) sq_mem.push_back(rand_wqe());
      for (int i = 0; i < vecs[v].n_rq; i++) rq_mem.push_back(rand_wqe());
      fifo_refresh();
      enable = 1'b1;
      drain(200);
      check("vec_grants", gnt_log.size(), vecs[v].n_g);
      for (int i = 0; i < vecs[v].n_g && i < gnt_log.size(); i++)
        check("vec_seq", gnt_log[i], vecs[v].seq[i]);
    end

    // Single SQ entry, no stalls.
    do_reset();
    sq_mem.push_back(112'h1234_5678_9abc_def0_0f1e_2d3c_abcd);
    fifo_refresh();
    enable = 1'b1;
    drain(50);
    check("single_pops", n_pops, 1);
    check("single_busy", busy_seen, 5);
    check("single_writes", log_q.size(), 5);
    for (int i = 0; i < 5 && i < log_q.size(); i++) begin
      check("single_addr", log_q[i].a, single[i].a);
      check("single_data", log_q[i].d, single[i].d);
      check("single_be", log_q[i].be, single[i].be);
    end

    // Three-cycle stall on beat 2.
    do_reset();
    sq_mem.push_back(rand_wqe());
    fifo_refresh();
    enable = 1'b1;
    wait_addr(BASE + 8'd2, 20);
    begin
      logic [31:0] snap;
      int held;
      snap = dcsWriteData;
      held = 0;
      for (int i = 0; i < 4; i++) begin
        dcsWaitRequest = (i < 3);
        if (dcsAddress == BASE + 8'd2 && dcsWriteData == snap) held++;
        tick();
      end
      check("stall_held", held, 4);
      check("stall_next", dcsAddress, BASE + 8'd3);
    end
    drain(50);
    check("stall_writes", log_q.size(), 5);

    // Enable drops during beat 1.
    do_reset();
    sq_mem.push_back(rand_wqe());
    sq_mem.push_back(rand_wqe());
    fifo_refresh();
    enable = 1'b1;
    wait_addr(BASE + 8'd1, 20);
    enable = 1'b0;
    repeat (20) tick();
    check("endrop_pops", n_pops, 1);
    check("endrop_finished", exp_q.size(), 0);
    check("endrop_idle", busy, 1'b0);
    enable = 1'b1;
    drain(50);
    check("endrop_resume", n_pops, 2);

    // Reset during beat 2.
    do_reset();
    for (int i = 0; i < 2; i++) begin
      sq_mem.push_back(rand_wqe());
      rq_mem.push_back(rand_wqe());
    end
    fifo_refresh();
    enable = 1'b1;
    wait_addr(BASE + 8'd2, 20);
    #2;
    reset = 1'b0;
    #1;
    check("arst_cs", dcsChipSelect, 1'b0);
    check("arst_we", dcsWrite, 1'b0);
    check("arst_addr", dcsAddress, 8'h00);
    check("arst_data", dcsWriteData, 32'h0);
    check("arst_be", dcsByteEnable, 4'h0);
    check("arst_busy", busy, 1'b0);
    check("arst_grantQ", grantQ, 1'b0);
    check("arst_pops", {sqFifoPop, rqFifoPop}, 2'b00);
    exp_q.delete();
    gnt_log.delete();
    model_reset();
    prev_stall = 1'b0;
    repeat (2) tick();
    reset     = 1'b1;
    since_rst = 0;
    drain(100);
    check("arst_first_sq", gnt_log.size() != 0 && gnt_log[0] == 1'b0, 1'b1);

    // Randomised traffic, stalls and enable toggling.
    do_reset();
    enable    = 1'b1;
    rand_wait = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      if (sq_mem.size() < 8 && $urandom_range(0, 3) == 0)
        sq_mem.push_back(rand_wqe());
      if (rq_mem.size() < 8 && $urandom_range(0, 4) == 0)
        rq_mem.push_back(rand_wqe());
      if ($urandom_range(0, 29) == 0) enable = ~enable;
      fifo_refresh();
      tick();
    end
    enable    = 1'b1;
    rand_wait = 1'b0;
    dcsWaitRequest = 1'b0;
    drain(2000);

`ifdef DMA_ARB_STATS_EN
    do_reset();
    for (int i = 0; i < 3; i++) sq_mem.push_back(rand_wqe());
    for (int i = 0; i < 2; i++) rq_mem.push_back(rand_wqe());
    fifo_refresh();
    enable = 1'b1;
    drain(200);
    check("stat_sq", sqGrantCnt, 16'd3);
    check("stat_rq", rqGrantCnt, 16'd2);
    statClear = 1'b1;
    tick();
    statClear = 1'b0;
    check("stat_sq_clr", sqGrantCnt, 16'd0);
    check("stat_rq_clr", rqGrantCnt, 16'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
